proc_sequencer: RTL

PROC_SEQUENCER -- requirements
Module: proc_sequencer

---
 rtl/proc_sequencer_pkg.sv | 30 +++
 rtl/proc_sequencer_if.sv | 28 ++
 rtl/proc_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, watchdog limit,
// FSM state encoding and a small opcode extraction helper.
package proc_sequencer_pkg;

    // Opcodes the sequencer itself has to recognise (low nibble of a word).
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Number of consecutive EXEC cycles without Done before giving up.
    localparam int WDOG_LIMIT = 7;
    localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_FETCH_IMM = 4'd3,
        S_LOAD_IMM  = 4'd4,
        S_ISSUE     = 4'd5,
        S_EXEC      = 4'd6,
        S_HALTED    = 4'd7,
        S_ERROR     = 4'd8
    } state_t;

    // Opcode field of an instruction word.
    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[3:0];
    endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Bus between the sequencer, its instruction ROM and the processor it drives.
interface proc_sequencer_if;

    logic [7:0]  imem_addr;  // ROM word address
    logic [15:0] imem_data;  // ROM data, one cycle after imem_addr
    logic [15:0] DIN;        // instruction / immediate word to processor
    logic        Run;        // processor enable
    logic        Done;       // processor instruction complete (combinational)

    // Sequencer side.
    modport master (
        output imem_addr,
        output DIN,
        output Run,
        input  imem_data,
        input  Done
    );

    // ROM / processor side.
    modport slave (
        input  imem_addr,
        input  DIN,
        input  Run,
        output imem_data,
        output Done
    );

endinterface

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches words from a synchronous ROM, fetches the
// immediate for mvi, feeds the processor through DIN/Run, counts completed
// instructions and traps processors that never raise Done.
module proc_sequencer
    import proc_sequencer_pkg::*;
(
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Start,
    proc_sequencer_if.master       bus,
    output logic                   Busy,
    output logic                   Halted,
    output logic                   Error,
    output logic [15:0]            instr_count
);

    state_t              state_q, state_d;
    logic [7:0]          pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [15:0]         imm_q, imm_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [15:0]         count_q, count_d;

    logic                run;
    logic                busy;
    logic                halted;
    logic                error;
    logic [15:0]         din;

    // State and datapath registers; reset drops everything (and Run) at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            wdog_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            wdog_q  <= wdog_d;
            count_q <= count_d;
        end
    end

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        wdog_d  = wdog_q;
        count_d = count_q;
        run     = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        error   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    count_d = '0;
                end
            end
            S_FETCH: begin
                // Address is already on the bus; data arrives next cycle.
                busy    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                busy    = 1'b1;
                instr_d = bus.imem_data;
                pc_d    = pc_q + 8'd1;
                if (opcode_of(bus.imem_data) == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (opcode_of(bus.imem_data) == OP_MVI) begin
                    state_d = S_FETCH_IMM;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FETCH_IMM: begin
                busy    = 1'b1;
                state_d = S_LOAD_IMM;
            end
            S_LOAD_IMM: begin
                busy    = 1'b1;
                imm_d   = bus.imem_data;
                pc_d    = pc_q + 8'd1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // Processor loads its IR here; Done is not looked at yet.
                busy    = 1'b1;
                run     = 1'b1;
                wdog_d  = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                run  = 1'b1;
                if (bus.Done) begin
                    count_d = count_q + 16'd1;
                    state_d = S_FETCH;
                end else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    count_d = '0;
                end
            end
            S_ERROR: begin
                // Only a reset gets out of here.
                error = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // During EXEC of an mvi the processor wants the immediate, otherwise
        // the instruction word; DIN is quiet whenever the processor is idle.
        din = '0;
        if (run) begin
            if (state_q == S_EXEC && opcode_of(instr_q) == OP_MVI) begin
                din = imm_q;
            end else begin
                din = instr_q;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.DIN       = din;
    assign bus.Run       = run;
    assign Busy          = busy;
    assign Halted        = halted;
    assign Error         = error;
    assign instr_count   = count_q;

endmodule
